// File: rtl/reg_bank.sv
// reg_bank: general-purpose register file with a pending scoreboard
// plus HI/LO, IR and MAR special registers.
module reg_bank #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rsv_en,
  input  logic [ADDR_W-1:0]  rsv_addr,
  input  logic [ADDR_W-1:0]  rd_addr_a,
  input  logic [ADDR_W-1:0]  rd_addr_b,
  output logic [WIDTH-1:0]   rd_data_a,
  output logic [WIDTH-1:0]   rd_data_b,
  output logic               rd_pend_a,
  output logic               rd_pend_b,
  input  logic               hilo_en,
  input  logic [2*WIDTH-1:0] z_in,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  input  logic               ir_en,
  input  logic               mar_en,
  output logic [WIDTH-1:0]   ir_out,
  output logic [WIDTH-1:0]   mar_out,
  output logic               any_pend
);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] wr_dec;
  logic [NUM_REGS-1:0] rsv_dec;
  logic                wr_ok;
  logic                rsv_ok;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    ir_q;
  logic [WIDTH-1:0]    mar_q;

  // An address is live when in range and not the hardwired zero register.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    live = (int'(a) < NUM_REGS) && !(R0_ZERO && (a == '0));
  endfunction

  assign wr_ok  = wr_en && live(wr_addr);
  assign rsv_ok = rsv_en && live(rsv_addr);

  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_dec[i]  = wr_ok && (wr_addr == ADDR_W'(i));
      rsv_dec[i] = rsv_ok && (rsv_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_dec[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  // Reserve wins over a same-edge write to the same register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~wr_dec) | rsv_dec;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hi_q  <= '0;
      lo_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
    end else begin
      if (hilo_en) begin
        hi_q <= z_in[2*WIDTH-1:WIDTH];
        lo_q <= z_in[WIDTH-1:0];
      end
      if (ir_en) begin
        ir_q <= wr_data;
      end
      if (mar_en) begin
        mar_q <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_pend_a = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((rd_addr_a == ADDR_W'(i)) && !(R0_ZERO && (i == 0))) begin
        rd_data_a = regs[i];
        rd_pend_a = pend[i];
      end
    end
    if (BYPASS && clear && wr_ok && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = '0;
    rd_pend_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((rd_addr_b == ADDR_W'(i)) && !(R0_ZERO && (i == 0))) begin
        rd_data_b = regs[i];
        rd_pend_b = pend[i];
      end
    end
    if (BYPASS && clear && wr_ok && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign ir_out   = ir_q;
  assign mar_out  = mar_q;
  assign any_pend = |pend;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed checks of reg_bank against a bench model,
// default instance plus a no-bypass, no-R0, 12-register instance.
module tb_reg_bank;

  localparam int W  = 32;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          clear;
  logic          wr_en, rsv_en, hilo_en, ir_en, mar_en;
  logic [AW-1:0] wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
  logic [W-1:0]  wr_data;
  logic [2*W-1:0] z_in;

  logic [1:0][W-1:0] da, db, hi, lo, ir, mar;
  logic [1:0]        pa, pb, ap;

  int n_run  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  reg_bank u_dut (
    .clock(clock), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da[0]), .rd_data_b(db[0]),
    .rd_pend_a(pa[0]), .rd_pend_b(pb[0]),
    .hilo_en(hilo_en), .z_in(z_in),
    .hi_out(hi[0]), .lo_out(lo[0]),
    .ir_en(ir_en), .mar_en(mar_en),
    .ir_out(ir[0]), .mar_out(mar[0]),
    .any_pend(ap[0])
  );

  reg_bank #(
    .NUM_REGS(12), .R0_ZERO(1'b0), .BYPASS(1'b0)
  ) u_alt (
    .clock(clock), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da[1]), .rd_data_b(db[1]),
    .rd_pend_a(pa[1]), .rd_pend_b(pb[1]),
    .hilo_en(hilo_en), .z_in(z_in),
    .hi_out(hi[1]), .lo_out(lo[1]),
    .ir_en(ir_en), .mar_en(mar_en),
    .ir_out(ir[1]), .mar_out(mar[1]),
    .any_pend(ap[1])
  );

  always #5 clock = ~clock;

  // ---- model ----
  logic [W-1:0] m_reg  [2][16];
  bit           m_pend [2][16];
  logic [W-1:0] m_hi, m_lo, m_ir, m_mar;

  function automatic int nregs(int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic bit live(int k, logic [AW-1:0] a);
    return (int'(a) < nregs(k)) && !((k == 0) && (a == 0));
  endfunction

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 16; i++) begin
          m_reg[k][i]  <= '0;
          m_pend[k][i] <= 1'b0;
        end
      end
      m_hi  <= '0;
      m_lo  <= '0;
      m_ir  <= '0;
      m_mar <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en && live(k, wr_addr)) begin
          m_reg[k][wr_addr]  <= wr_data;
          m_pend[k][wr_addr] <= 1'b0;
        end
        if (rsv_en && live(k, rsv_addr)) begin
          m_pend[k][rsv_addr] <= 1'b1;
        end
      end
      if (hilo_en) begin
        m_hi <= z_in[63:32];
        m_lo <= z_in[31:0];
      end
      if (ir_en) m_ir <= wr_data;
      if (mar_en) m_mar <= wr_data;
    end
  end

  function automatic logic [W-1:0] e_data(int k, logic [AW-1:0] a);
    if (!clear || !live(k, a)) return '0;
    if ((k == 0) && wr_en && live(k, wr_addr) && (wr_addr == a))
      return wr_data;
    return m_reg[k][a];
  endfunction

  function automatic bit e_pend(int k, logic [AW-1:0] a);
    if (!clear || !live(k, a)) return 1'b0;
    return m_pend[k][a];
  endfunction

  function automatic bit e_any(int k);
    bit r = 1'b0;
    for (int i = 0; i < nregs(k); i++) r |= m_pend[k][i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m_rd_data_a%0d", k), 64'(da[k]), 64'(e_data(k, rd_addr_a)));
        chk($sformatf("m_rd_data_b%0d", k), 64'(db[k]), 64'(e_data(k, rd_addr_b)));
        chk($sformatf("m_rd_pend_a%0d", k), 64'(pa[k]), 64'(e_pend(k, rd_addr_a)));
        chk($sformatf("m_rd_pend_b%0d", k), 64'(pb[k]), 64'(e_pend(k, rd_addr_b)));
        chk($sformatf("m_any_pend%0d", k), 64'(ap[k]), 64'(e_any(k)));
        chk($sformatf("m_hi%0d", k), 64'(hi[k]), 64'(m_hi));
        chk($sformatf("m_lo%0d", k), 64'(lo[k]), 64'(m_lo));
        chk($sformatf("m_ir%0d", k), 64'(ir[k]), 64'(m_ir));
        chk($sformatf("m_mar%0d", k), 64'(mar[k]), 64'(m_mar));
      end
    end
  end

  // ---- stimulus ----
  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } vec_t;

  vec_t tbl [8] = '{
    '{1'b1, 4'd10, 32'h0000_000A, 1'b0, 4'd0,  4'd10, 4'd9},
    '{1'b1, 4'd1,  32'h1111_1111, 1'b1, 4'd2,  4'd1,  4'd2},
    '{1'b1, 4'd2,  32'h2222_2222, 1'b1, 4'd2,  4'd2,  4'd1},
    '{1'b0, 4'd0,  32'h0000_0000, 1'b1, 4'd11, 4'd11, 4'd2},
    '{1'b1, 4'd11, 32'hBBBB_0000, 1'b0, 4'd0,  4'd11, 4'd11},
    '{1'b1, 4'd12, 32'hC0C0_C0C0, 1'b1, 4'd12, 4'd12, 4'd12},
    '{1'b1, 4'd2,  32'h2222_0002, 1'b0, 4'd0,  4'd2,  4'd12},
    '{1'b1, 4'd12, 32'h0000_0000, 1'b0, 4'd0,  4'd12, 4'd0}
  };

  task automatic idle();
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    hilo_en = 1'b0;
    ir_en   = 1'b0;
    mar_en  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b0;
    idle();
    wr_addr = '0; rsv_addr = '0; wr_data = '0; z_in = '0;
    rd_addr_a = 4'd3; rd_addr_b = 4'd0;
    #2;
    chk("rst_data", 64'(da[0]), 64'h0);
    chk("rst_any", 64'(ap[0]), 64'h0);
    tick();
    clear = 1'b1;
    chk_en = 1'b1;
    tick();

    // basic write, next-cycle read
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
    tick();
    idle();
    rd_addr_a = 4'd3; rd_addr_b = 4'd2;
    #1;
    chk("wr3_dut", 64'(da[0]), 64'hDEAD_BEEF);
    chk("wr3_alt", 64'(da[1]), 64'hDEAD_BEEF);
    chk("wr3_other", 64'(db[0]), 64'h0);

    // register 0
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234_5678;
    rsv_en = 1'b1; rsv_addr = 4'd0;
    tick();
    idle();
    rd_addr_a = 4'd0;
    #1;
    chk("r0_data", 64'(da[0]), 64'h0);
    chk("r0_pend", 64'(pa[0]), 64'h0);
    chk("r0_any", 64'(ap[0]), 64'h0);
    chk("r0_alt_data", 64'(da[1]), 64'h1234_5678);
    chk("r0_alt_pend", 64'(pa[1]), 64'h1);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0;
    tick();

    // bypass vs no bypass
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hA5A5_A5A5;
    rd_addr_b = 4'd5;
    #1;
    chk("byp_on", 64'(db[0]), 64'hA5A5_A5A5);
    chk("byp_off", 64'(db[1]), 64'h0);
    tick();
    idle();
    #1;
    chk("byp_off_next", 64'(db[1]), 64'hA5A5_A5A5);

    // reserve / write interplay on 7
    rsv_en = 1'b1; rsv_addr = 4'd7;
    tick();
    rsv_en = 1'b1; rsv_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h1;
    rd_addr_a = 4'd7;
    #1;
    chk("rsv7_pend_pre", 64'(pa[0]), 64'h1);
    tick();
    idle();
    #1;
    chk("rsv7_pend", 64'(pa[0]), 64'h1);
    chk("rsv7_data", 64'(da[0]), 64'h1);
    chk("rsv7_any", 64'(ap[0]), 64'h1);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h2;
    tick();
    idle();
    #1;
    chk("wr7_pend", 64'(pa[0]), 64'h0);
    chk("wr7_any", 64'(ap[0]), 64'h0);
    chk("wr7_data", 64'(da[0]), 64'h2);

    // HI/LO
    hilo_en = 1'b1; z_in = 64'h0000_0001_FFFF_FFFE;
    tick();
    idle();
    rd_addr_a = 4'd3;
    #1;
    chk("hi", 64'(hi[0]), 64'h1);
    chk("lo", 64'(lo[0]), 64'hFFFF_FFFE);
    chk("hilo_gp", 64'(da[0]), 64'hDEAD_BEEF);

    // out-of-range on the 12-register instance
    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 4'd14;
    tick();
    idle();
    rd_addr_a = 4'd13; rd_addr_b = 4'd14;
    #1;
    chk("oor_dut", 64'(da[0]), 64'h77);
    chk("oor_alt", 64'(da[1]), 64'h0);
    chk("oor_pend_dut", 64'(pb[0]), 64'h1);
    chk("oor_pend_alt", 64'(pb[1]), 64'h0);
    chk("oor_any_alt", 64'(ap[1]), 64'h0);
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'h0;
    tick();
    idle();

    // all write paths in one cycle
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hCAFE_0009;
    ir_en = 1'b1; mar_en = 1'b1;
    hilo_en = 1'b1; z_in = 64'h1111_2222_3333_4444;
    rsv_en = 1'b1; rsv_addr = 4'd10;
    tick();
    idle();
    rd_addr_a = 4'd9; rd_addr_b = 4'd10;
    #1;
    chk("all_ir", 64'(ir[0]), 64'hCAFE_0009);
    chk("all_mar", 64'(mar[0]), 64'hCAFE_0009);
    chk("all_hi", 64'(hi[0]), 64'h1111_2222);
    chk("all_lo", 64'(lo[0]), 64'h3333_4444);
    chk("all_gp", 64'(da[0]), 64'hCAFE_0009);
    chk("all_pend", 64'(pb[0]), 64'h1);

    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rsv_en = tbl[i].re; rsv_addr = tbl[i].ra;
      rd_addr_a = tbl[i].a; rd_addr_b = tbl[i].b;
      tick();
    end
    idle();

    // load 1..4 and IR, then reset mid-cycle
    for (int r = 1; r <= 4; r++) begin
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = 32'h100 + 32'(r);
      tick();
    end
    ir_en = 1'b1; wr_en = 1'b0; wr_data = 32'h0000_1EAD;
    tick();
    idle();
    rd_addr_a = 4'd1; rd_addr_b = 4'd4;
    #1;
    chk("pre_rst_r1", 64'(da[0]), 64'h101);
    chk("pre_rst_ir", 64'(ir[0]), 64'h1EAD);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h66;
    ir_en = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd8;
    rd_addr_a = 4'd1;
    #1;
    clear = 1'b0;
    #1;
    chk("arst_r1", 64'(da[0]), 64'h0);
    chk("arst_r4", 64'(db[0]), 64'h0);
    chk("arst_ir", 64'(ir[0]), 64'h0);
    chk("arst_hi", 64'(hi[0]), 64'h0);
    chk("arst_lo", 64'(lo[0]), 64'h0);
    chk("arst_any", 64'(ap[0]), 64'h0);
    tick();
    rsv_en = 1'b0;
    rd_addr_a = 4'd6;
    clear = 1'b1;
    tick();
    idle();
    #1;
    chk("post_rst_wr", 64'(da[0]), 64'h66);
    chk("post_rst_alt", 64'(da[1]), 64'h66);
    chk("post_rst_ir", 64'(ir[0]), 64'h66);
    chk("post_rst_r4", 64'(db[0]), 64'h0);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
